// File: rtl/cic_ctrl_pkg.sv
// Shared types and defaults for the CIC sequencing controller.
package cic_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    WARMUP,
    RUN,
    DRAIN
  } cic_state_t;

  localparam int CIC_DIN_W  = 10;
  localparam int CIC_DOUT_W = 13;
  localparam int CIC_STAGES = 3;

  // A decimation setting of 0 or 1 both mean "no decimation".
  function automatic logic [7:0] effective_r(input logic [7:0] cfg_dec);
    return (cfg_dec < 8'd2) ? 8'd1 : cfg_dec;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; a push on full succeeds only when a pop
// happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             empty, do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/cic_seq_ctrl.sv
// Sequencing controller for a decimating CIC: sample/decimation strobes,
// filter clear with warm-up discard, and result capture into an output FIFO.
module cic_seq_ctrl
  import cic_ctrl_pkg::*;
#(
  parameter int DIN_W      = CIC_DIN_W,
  parameter int DOUT_W     = CIC_DOUT_W,
  parameter int STAGES     = CIC_STAGES,
  parameter int CIC_LAT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              cfg_div,
  input  logic [7:0]               cfg_dec,
  input  logic                     start,
  input  logic                     stop,
  input  logic signed [DIN_W-1:0]  adc_din,
  output logic signed [DIN_W-1:0]  cic_din,
  output logic                     cic_en,
  output logic                     cic_dec_en,
  output logic                     cic_clr,
  input  logic signed [DOUT_W-1:0] cic_dout,
  output logic signed [DOUT_W-1:0] m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     busy,
  output logic                     ovf
);
  localparam logic [7:0] CLR_LAST  = 8'(STAGES + 1);
  localparam logic [7:0] WARM_LAST = 8'(STAGES - 1);
  localparam logic [7:0] LAT_LAST  = 8'(CIC_LAT - 1);

  cic_state_t state, state_d;
  logic [15:0] div_s, div_cnt;
  logic [7:0]  r_s, dec_cnt, clr_cnt, warm_cnt, lat_cnt;
  logic        stop_pend, strobe_nxt, push, fifo_full;
  logic [CIC_LAT-1:0] push_vld_p;
  logic [$clog2(FIFO_DEPTH):0] fifo_cnt;

  assign busy       = (state != IDLE);
  assign cic_clr    = (state == CLEAR);
  assign cic_dec_en = cic_en && (dec_cnt == r_s - 8'd1);
  assign push       = push_vld_p[CIC_LAT-1];
  // Strobes are only issued while the filter stays in a streaming state.
  assign strobe_nxt = (state == WARMUP || state == RUN) &&
                      (state_d == WARMUP || state_d == RUN);

  always_comb begin
    state_d = state;
    case (state)
      IDLE:   if (start) state_d = CLEAR;
      CLEAR:  if (clr_cnt == CLR_LAST) state_d = (stop_pend || stop) ? IDLE : WARMUP;
      WARMUP: if (cic_dec_en) begin
                if (stop_pend)                  state_d = IDLE;
                else if (warm_cnt == WARM_LAST) state_d = RUN;
              end
      RUN:    if (cic_dec_en && stop_pend) state_d = DRAIN;
      DRAIN:  if (lat_cnt == LAT_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      div_s      <= '0;
      r_s        <= '0;
      div_cnt    <= '0;
      dec_cnt    <= '0;
      clr_cnt    <= '0;
      warm_cnt   <= '0;
      lat_cnt    <= '0;
      stop_pend  <= 1'b0;
      cic_en     <= 1'b0;
      cic_din    <= '0;
      push_vld_p <= '0;
      ovf        <= 1'b0;
    end else begin
      state   <= state_d;
      clr_cnt <= (state == CLEAR) ? clr_cnt + 8'd1 : '0;
      lat_cnt <= (state == DRAIN) ? lat_cnt + 8'd1 : '0;

      if (state == IDLE) stop_pend <= 1'b0;
      else if (stop)     stop_pend <= 1'b1;

      if (state == IDLE && start) begin
        div_s <= cfg_div;
        r_s   <= effective_r(cfg_dec);
      end

      if (state == CLEAR) begin
        dec_cnt  <= '0;
        warm_cnt <= '0;
      end else begin
        if (cic_dec_en && state == WARMUP) warm_cnt <= warm_cnt + 8'd1;
        if (cic_en) dec_cnt <= (dec_cnt == r_s - 8'd1) ? '0 : dec_cnt + 8'd1;
      end

      // p0: sample strobe and registered sample
      if (strobe_nxt && div_cnt == div_s) begin
        div_cnt <= '0;
        cic_en  <= 1'b1;
        cic_din <= adc_din;
      end else begin
        div_cnt <= strobe_nxt ? div_cnt + 16'd1 : '0;
        cic_en  <= 1'b0;
      end

      // p1..pN: capture valid follows the CIC latency; warm-up results carry no valid
      if (state == CLEAR) begin
        push_vld_p <= '0;
      end else begin
        push_vld_p[0] <= (state == RUN) && cic_dec_en;
        for (int i = 1; i < CIC_LAT; i++) push_vld_p[i] <= push_vld_p[i-1];
      end

      if (state == IDLE && start)          ovf <= 1'b0;
      else if (push && fifo_full && !m_ready) ovf <= 1'b1;
    end
  end

  assign m_valid = (fifo_cnt != '0);

  sync_fifo #(
    .WIDTH (DOUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (m_ready),
    .wdata (cic_dout),
    .rdata (m_data),
    .full  (fifo_full),
    .count (fifo_cnt)
  );

endmodule

// File: tb/tb_cic_seq_ctrl.sv
// Randomized bench for cic_seq_ctrl against a closed-form strobe schedule
// and a queue model of the output FIFO.
module tb_cic_seq_ctrl;
  localparam int S     = 3;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int INF   = 32'h3fff_ffff;

  logic               clk = 1'b0;
  logic               rst, start, stop, m_ready;
  logic [15:0]        cfg_div;
  logic [7:0]         cfg_dec;
  logic signed [9:0]  adc_din, cic_din;
  logic signed [12:0] cic_dout, m_data;
  logic               cic_en, cic_dec_en, cic_clr, m_valid, busy, ovf;

  always #5 clk = ~clk;

  cic_seq_ctrl dut (
    .clk(clk), .rst(rst), .cfg_div(cfg_div), .cfg_dec(cfg_dec),
    .start(start), .stop(stop), .adc_din(adc_din), .cic_din(cic_din),
    .cic_en(cic_en), .cic_dec_en(cic_dec_en), .cic_clr(cic_clr),
    .cic_dout(cic_dout), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .busy(busy), .ovf(ovf)
  );

  int n_chk = 0, n_pass = 0, n = 0;

  // Reference: one acquisition is described by its CLEAR start, WARMUP start,
  // last strobe cycle and first idle cycle; everything else is arithmetic.
  bit                 run_on = 0, stop_seen = 0, ovf_m = 0;
  int                 t_clr0, w, t_end, f_last, div_m, r_m;
  logic signed [9:0]  din_m = '0;
  logic signed [12:0] q[$];
  int                 pend[$];

  function automatic bit act(int c);
    return run_on && c >= t_clr0 && c < t_end;
  endfunction

  function automatic bit en_at(int c);
    if (!act(c) || c < w + div_m + 1 || c > f_last) return 0;
    return ((c - w - div_m - 1) % (div_m + 1)) == 0;
  endfunction

  function automatic int en_num(int c);
    return (c - w - div_m - 1) / (div_m + 1);
  endfunction

  function automatic bit dec_at(int c);
    return en_at(c) && ((en_num(c) + 1) % r_m) == 0;
  endfunction

  function automatic int dec_cycle(int m);
    return w + div_m + 1 + (m * r_m - 1) * (div_m + 1);
  endfunction

  task automatic chk(string tag, logic signed [31:0] got, logic signed [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0d expected %0d", tag, n, got, exp);
  endtask

  task automatic model_edge();
    bit push, pop;
    int m, d;
    if (!rst) begin
      run_on = 0; stop_seen = 0; ovf_m = 0; din_m = '0;
      q.delete(); pend.delete();
      return;
    end
    push = (pend.size() > 0) && (pend[0] == n);
    if (push) void'(pend.pop_front());
    pop = m_ready && (q.size() > 0);
    if (push && q.size() == DEPTH && !pop) ovf_m = 1;
    else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(cic_dout);
    end
    if (dec_at(n) && ((en_num(n) + 1) / r_m - 1) >= S) pend.push_back(n + LAT);
    if (stop && act(n) && !stop_seen) begin
      stop_seen = 1;
      if (n < w) t_end = w;
      else begin
        m = 1;
        while (dec_cycle(m) <= n) m++;
        d = dec_cycle(m);
        f_last = d;
        t_end = (m - 1 >= S) ? d + LAT + 1 : d + 1;
      end
    end
    if (start && !act(n)) begin
      run_on = 1; stop_seen = 0; ovf_m = 0;
      t_clr0 = n + 1; w = t_clr0 + S + 2;
      t_end = INF; f_last = INF;
      div_m = int'(cfg_div);
      r_m = (cfg_dec < 2) ? 1 : int'(cfg_dec);
    end
    if (en_at(n + 1)) din_m = adc_din;
  endtask

  task automatic check_all();
    logic signed [12:0] head;
    head = (q.size() > 0) ? q[0] : 13'sd0;
    chk("busy",       busy,       act(n));
    chk("cic_clr",    cic_clr,    act(n) && n < w);
    chk("cic_en",     cic_en,     en_at(n));
    chk("cic_dec_en", cic_dec_en, dec_at(n));
    chk("cic_din",    cic_din,    din_m);
    chk("m_valid",    m_valid,    q.size() > 0);
    chk("m_data",     m_data,     head);
    chk("ovf",        ovf,        ovf_m);
  endtask

  task automatic step();
    adc_din  = 10'($urandom);
    cic_dout = 13'($urandom);
    @(posedge clk);
    model_edge();
    #1;
    n++;
    check_all();
  endtask

  // rmode: 0 ready held high, 1 random ready, 2 ready low for most of the run
  task automatic run_scen(int dv, int dc, int len, int rmode, bit mid_rst, bit poke, bit ss);
    cfg_div = 16'(dv); cfg_dec = 8'(dc);
    start = 1; stop = ss;
    step();
    start = 0; stop = 0;
    for (int i = 0; i < len; i++) begin
      m_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom_range(0, 1)) : (i >= len * 3 / 4);
      if (poke && i == len / 2) begin
        start = 1; cfg_div = 16'($urandom_range(0, 7)); cfg_dec = 8'($urandom_range(0, 255));
      end
      if (mid_rst && i == len / 2) rst = 0;
      step();
      start = 0; rst = 1;
    end
    stop = 1;
    step();
    stop = 0; m_ready = 1;
    for (int i = 0; i < 4000 && act(n); i++) step();
    chk("idle_after_stop", busy, 1'b0);
    for (int i = 0; i < 8; i++) step();
  endtask

  initial begin
    rst = 0; start = 0; stop = 0; m_ready = 0;
    cfg_div = '0; cfg_dec = '0; adc_din = '0; cic_dout = '0;
    repeat (3) step();
    rst = 1;
    step();
    run_scen(4, 8, 400, 0, 0, 0, 1);
    run_scen(0, 0, 60, 0, 0, 0, 0);
    run_scen(1, 2, 200, 2, 0, 0, 0);
    run_scen(4, 8, 600, 1, 0, 1, 0);
    run_scen(4, 8, 330, 1, 1, 0, 0);
    run_scen(4, 8, 400, 0, 0, 0, 0);
    run_scen(3, 4, 2, 0, 0, 0, 0);
    run_scen(1, 4, 20, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++)
      run_scen($urandom_range(0, 5), $urandom_range(0, 6), $urandom_range(0, 300),
               $urandom_range(0, 2), $urandom_range(0, 4) == 0,
               $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cic_seq_ctrl.md
Name: cic_seq_ctrl

Overview:
Sequencing controller for the decimating CIC datapath (10-bit signed in, 13-bit signed out).
- Generates the input-sample strobe and the decimation (comb) strobe.
- Clears filter state on start and discards settling outputs.
- Captures CIC results into a small output FIFO with a valid/ready interface.
- Sits between the ADC sample source, the CIC instance and the downstream consumer.

Parameters:
DIN_W, 10, input sample width (signed)
DOUT_W, 13, CIC output width (signed)
STAGES, 3, CIC order; sets clear length and number of discarded warm-up outputs
CIC_LAT, 2, clk cycles from cic_dec_en to valid cic_dout
FIFO_DEPTH, 4, output FIFO entries (power of 2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
cfg_div  in  16  sample period minus 1 (strobe every cfg_div+1 clks); sampled at start
cfg_dec  in  8  decimation ratio R; 0 and 1 both mean R=1; sampled at start
start  in  1  one-cycle pulse; begin acquisition
stop  in  1  one-cycle pulse; end acquisition after current decimation frame
adc_din  in  DIN_W  raw sample
cic_din  out  DIN_W  registered sample to CIC
cic_en  out  1  input-sample strobe (integrator enable)
cic_dec_en  out  1  decimation strobe (comb enable)
cic_clr  out  1  synchronous filter-state clear
cic_dout  in  DOUT_W  CIC result
m_data  out  DOUT_W  FIFO head
m_valid  out  1  FIFO non-empty
m_ready  in  1  consumer accepts m_data when m_valid && m_ready
busy  out  1  state != IDLE
ovf  out  1  sticky; a result was dropped on a full FIFO

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE; all counters 0; FIFO emptied.
  - Outputs: cic_en=0, cic_dec_en=0, cic_clr=0, cic_din=0, m_valid=0, m_data=0, ovf=0, busy=0.
  - Reset asserted mid-operation aborts immediately; no flush.
- FSM:
  - IDLE: start -> CLEAR. Latch cfg_div and cfg_dec into shadow registers; clear ovf.
  - CLEAR: cic_clr=1 for exactly STAGES+2 cycles, then -> WARMUP. No strobes are issued.
  - WARMUP: strobes run. The first STAGES decimated results are discarded (not pushed), then -> RUN.
  - RUN: every decimated result is pushed to the FIFO. stop sets stop_pend.
  - stop_pend handling: on the cycle cic_dec_en fires with stop_pend set -> DRAIN.
  - DRAIN: strobes off. Wait CIC_LAT cycles, push the final result, then -> IDLE. The FIFO keeps draining via m_ready.
  - stop in WARMUP: -> IDLE after the next cic_dec_en; no push.
  - stop in CLEAR: -> IDLE at the end of CLEAR.
  - start while busy is ignored. start and stop in the same IDLE cycle: start wins; stop is ignored.
- Sample strobe:
  - div_cnt counts 0..cfg_div. cic_en=1 for one cycle when div_cnt==cfg_div, then div_cnt wraps to 0.
  - cfg_div=0 gives cic_en every cycle.
  - cic_din <= adc_din on the same edge that raises cic_en (registered, aligned with cic_en).
- Decimation:
  - dec_cnt increments on each cic_en.
  - When dec_cnt==R-1 and cic_en=1: cic_dec_en=1 in that same cycle and dec_cnt wraps to 0.
- Capture:
  - cic_dec_en is delayed by a CIC_LAT-deep shift register. Its output push_req samples cic_dout.
  - The shift register is cleared on CLEAR and on reset.
- FIFO:
  - Push and pop in the same cycle are allowed, including when full: both succeed and the count is unchanged.
  - Push on full without a pop: the data is dropped and ovf=1, sticky until the next start or reset.
  - Pop on empty: no effect.
  - m_data holds the head value (show-ahead). m_data is stable while m_valid && !m_ready.
- Arithmetic:
  - All counters are unsigned and wrap only at their compare values.
  - Data passes through unmodified; no sign or width changes.

Decomposition:
- Package cic_ctrl_pkg holds:
  - state enum: IDLE, CLEAR, WARMUP, RUN, DRAIN
  - DIN_W, DOUT_W and STAGES defaults
  - function effective_r(cfg_dec), returning 1 when cfg_dec<2
- Sub-module sync_fifo (parameters WIDTH, DEPTH) implements the show-ahead FIFO with full/empty/count and the simultaneous push/pop rule.

Test Plan:
1. Reset, then cfg_div=4, cfg_dec=8, start -> cic_clr high exactly 5 cycles. cic_en every 5 clks; cic_dec_en on every 8th cic_en (every 40 clks). First push at the 4th cic_dec_en + CIC_LAT clks.
2. cfg_div=0, cfg_dec=0 -> cic_en and cic_dec_en high every cycle after CLEAR. Results are pushed every cycle after 3 discarded; m_ready=1 keeps m_valid continuous.
3. m_ready=0 with 6 decimated results in RUN -> FIFO holds the first 4, ovf=1. Then raise m_ready -> exactly 4 values read, in order, with no duplicates.
4. stop 3 cic_en after a cic_dec_en in RUN (R=8) -> strobes continue to the next cic_dec_en. One final push, then busy=0 CIC_LAT+1 clks later.
5. rst=0 for one cycle during RUN with FIFO count=2 -> next cycle all outputs are at reset values and m_valid=0. A subsequent start behaves exactly as scenario 1.
6. start pulse while in RUN plus cfg_dec change -> ignored; decimation stays 8 and ovf is not cleared.
